// File: rtl/byte_ram.sv
// rtl/byte_ram.sv - single-port byte-writable RAM with fixed-latency request/response handshake
module byte_ram #(
    parameter int DATA_W  = 32,
    parameter int WORDS   = 4096,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W/8-1:0] req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int AW  = $clog2(WORDS);
    localparam int HI  = OFF + AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    // Storage starts at zero so every read returns defined data on all lanes.
    logic [DATA_W-1:0] mem [WORDS] = '{default: '0};

    logic [AW-1:0] idx;
    logic          oor;
    logic          is_write;
    logic          accept;
    logic          unused_addr;

    // Word index, range check and accept qualification; bit 31 selects an
    // address space and is deliberately not decoded.
    always_comb begin
        idx         = req_addr[OFF +: AW];
        oor         = |(req_addr[30:0] >> HI);
        is_write    = |req_we;
        accept      = (state_q == S_IDLE) && req_valid && !rst;
        unused_addr = req_addr[31];
    end

    // Next-state logic; the response word is captured at accept so later
    // writes cannot change a read that is already in flight.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    err_d   = oor;
                    rdata_d = (oor || is_write) ? '0 : mem[idx];
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and response registers; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte-lane write on the accept edge; memory is untouched by reset.
    always_ff @(posedge clk) begin
        if (accept && is_write && !oor) begin
            for (int i = 0; i < NB; i++) begin
                if (req_we[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_byte_ram.sv
// tb/tb_byte_ram.sv - self-checking bench for byte_ram at LATENCY 1 and 4
module tb_byte_ram;

    logic        clk;
    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [3:0]  req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int total = 0;
    int bad   = 0;
    int lat [2] = '{1, 4};
    logic [31:0] model [2][4096];

    byte_ram #(.DATA_W(32), .WORDS(4096), .LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    byte_ram #(.DATA_W(32), .WORDS(4096), .LATENCY(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    task automatic drive_junk(input int d);
        req_valid[d] = 1'b1;
        req_we[d]    = 4'hF;
        req_addr[d]  = 32'($urandom_range(0, 15)) << 2;
        req_wdata[d] = $urandom;
    endtask

    task automatic idle_req(input int d);
        req_valid[d] = 1'b0;
        req_we[d]    = 4'h0;
        req_addr[d]  = 32'h0;
        req_wdata[d] = 32'h0;
    endtask

    // One complete transaction; called just after a falling edge.
    task automatic txn(input int d, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold, input bit junk,
                       output logic [31:0] obs);
        logic        oor;
        logic [11:0] wi;
        logic [31:0] exp_r;
        logic        exp_e;
        int          n;
        oor = |addr[30:14];
        wi  = addr[13:2];
        if (oor) begin
            exp_r = 32'h0;
            exp_e = 1'b1;
        end else if (we != 4'h0) begin
            exp_r = 32'h0;
            exp_e = 1'b0;
            model[d][wi] = merge(model[d][wi], wd, we);
        end else begin
            exp_r = model[d][wi];
            exp_e = 1'b0;
        end
        chk("req_ready_idle", 32'(req_ready[d]), 32'h1);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_addr[d]   = addr;
        req_wdata[d]  = wd;
        resp_ready[d] = 1'b0;
        @(negedge clk);
        if (junk) drive_junk(d); else idle_req(d);
        n = 1;
        while (!resp_valid[d] && n < 40) begin
            chk("req_ready_busy", 32'(req_ready[d]), 32'h0);
            @(negedge clk);
            if (junk) drive_junk(d);
            n++;
        end
        chk("latency", 32'(n), 32'(lat[d]));
        chk("rdata", resp_rdata[d], exp_r);
        chk("err", 32'(resp_err[d]), 32'(exp_e));
        obs = resp_rdata[d];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (junk) drive_junk(d);
            chk("hold_valid", 32'(resp_valid[d]), 32'h1);
            chk("hold_rdata", resp_rdata[d], exp_r);
            chk("hold_ready", 32'(req_ready[d]), 32'h0);
        end
        idle_req(d);
        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
        chk("release_valid", 32'(resp_valid[d]), 32'h0);
        chk("release_ready", 32'(req_ready[d]), 32'h1);
    endtask

    initial begin
        logic [31:0] obs;
        logic [31:0] a;
        logic [3:0]  we;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4096; i++) model[d][i] = 32'h0;
            idle_req(d);
            resp_ready[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_resp_valid", 32'(resp_valid[d]), 32'h0);
            chk("rst_rdata", resp_rdata[d], 32'h0);
            chk("rst_err", 32'(resp_err[d]), 32'h0);
            chk("rst_req_ready", 32'(req_ready[d]), 32'h1);
        end
        rst = 1'b0;
        @(negedge clk);

        // Full write then read through the alternate address space.
        txn(0, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, obs);
        txn(0, 4'h0, 32'h8000_0010, 32'h0, 0, 0, obs);
        chk("full_rw", obs, 32'hDEAD_BEEF);

        // Partial write over the same word.
        txn(0, 4'b0101, 32'h0000_0010, 32'h1122_3344, 0, 0, obs);
        txn(0, 4'h0, 32'h0000_0010, 32'h0, 0, 0, obs);
        chk("partial", obs, 32'hDE22_BE44);

        // Latency 4 with three cycles of backpressure and ignored requests.
        txn(1, 4'hF, 32'h0000_0008, 32'h0BAD_F00D, 0, 0, obs);
        txn(1, 4'h0, 32'h0000_0008, 32'h0, 3, 1, obs);
        chk("lat4_data", obs, 32'h0BAD_F00D);

        // Out-of-range write must not alias onto word 0.
        txn(0, 4'hF, 32'h0000_0000, 32'hA5A5_A5A5, 0, 0, obs);
        txn(0, 4'hF, 32'h0000_4000, 32'hFFFF_FFFF, 1, 0, obs);
        chk("oor_rdata", obs, 32'h0);
        txn(0, 4'h0, 32'h0000_0000, 32'h0, 0, 0, obs);
        chk("oor_unchanged", obs, 32'hA5A5_A5A5);

        // Reset during WAIT of a read.
        txn(1, 4'hF, 32'h0000_0020, 32'hCAFE_F00D, 0, 0, obs);
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h0000_0020;
        @(negedge clk);
        idle_req(1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", 32'(resp_valid[1]), 32'h0);
        chk("midrst_ready", 32'(req_ready[1]), 32'h1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("midrst_no_resp", 32'(resp_valid[1]), 32'h0);
        end
        txn(1, 4'h0, 32'h0000_0020, 32'h0, 0, 0, obs);
        chk("midrst_reread", obs, 32'hCAFE_F00D);

        // Stale read dropped by reset; a write presented during reset is ignored.
        txn(0, 4'hF, 32'h0000_0030, 32'h1357_9BDF, 0, 0, obs);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h0000_0030;
        @(negedge clk);
        chk("stale_presented", 32'(resp_valid[0]), 32'h1);
        req_we[0]    = 4'hF;
        req_wdata[0] = 32'h1234_5678;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_req(0);
        chk("stale_dropped", 32'(resp_valid[0]), 32'h0);
        txn(0, 4'h0, 32'h0000_0030, 32'h0, 0, 0, obs);
        chk("rst_priority", obs, 32'h1357_9BDF);
        txn(0, 4'hF, 32'h0000_0030, 32'h55AA_55AA, 0, 0, obs);
        txn(0, 4'h0, 32'h0000_0030, 32'h0, 0, 0, obs);
        chk("stale_newval", obs, 32'h55AA_55AA);

        // Randomised traffic against the reference model.
        for (int t = 0; t < 80; t++) begin
            a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            a[31] = 1'($urandom);
            if ($urandom_range(0, 7) == 0) a[$urandom_range(14, 30)] = 1'b1;
            we = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) we = 4'h0;
            txn(t % 2, we, a, $urandom, $urandom_range(0, 3), 1'($urandom), obs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
